uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, sent LSB first.
REQ-002 Parameter PAR_TYP, default 0, expected parity: 0 = even, 1 = odd.
REQ-003 Parameter SB_TICK, default 16, ticks per stop bit (16 = one stop bit).
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port tick  input  1  one-clk baud strobe at 16x the bit rate, shared with the transmitter.
REQ-007 Port rx  input  1  asynchronous serial line, idle high.
REQ-008 Port rx_data  output  DATA_BITS  last received data word, registered.
REQ-009 Port rx_done  output  1  one-clk pulse when a frame completes, good or errored.
REQ-010 Port parity_err  output  1  parity mismatch on the last frame; valid from rx_done and held until the next rx_done.
REQ-011 Port frame_err  output  1  stop bit sampled low on the last frame; same validity as parity_err.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer; all FSM decisions SHALL use the synchronized value (rx_s).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, plus a 4-bit tick counter and a bit counter sized to reach DATA_BITS-1.
REQ-014 IDLE: when rx_s==0, the FSM SHALL clear the tick and bit counters and go to START; this check does not wait for tick.
REQ-015 START: on each tick the FSM SHALL increment the tick counter; at count 7 (mid start bit) it SHALL go to DATA if rx_s==0, else return to IDLE as a false start with no rx_done.
REQ-016 DATA: on the tick at count 15 the FSM SHALL shift rx_s into the data shift register MSB, shifting right, so the LSB arrives first.
REQ-017 DATA: after the DATA_BITS-th sample the FSM SHALL go to PARITY and clear the bit counter.
REQ-018 PARITY: on the tick at count 15 the FSM SHALL compare rx_s with the expected bit (PAR_TYP ? ~^data : ^data), latch the mismatch flag, and go to STOP.
REQ-019 STOP: on the tick at count SB_TICK-1 the FSM SHALL sample rx_s (0 sets the frame error flag) and return to IDLE.
REQ-020 The same STOP sample SHALL load rx_data, parity_err and frame_err, and SHALL assert rx_done on the next clk for exactly one clk.
REQ-021 A frame SHALL complete even with errors, and rx_data SHALL hold the received word.
REQ-022 Without tick, the counters and FSM SHALL hold; only the IDLE start detect runs without tick.
REQ-023 Back-to-back frames: a start bit beginning on the tick right after STOP SHALL be detected with no lost frame.
REQ-024 Illegal state encodings SHALL go to IDLE on the next clk.

Reset
REQ-025 When rst=1 at a clk edge: FSM to IDLE, counters and shift register to 0, synchronizer flops to 1.
REQ-026 Reset values of outputs: rx_data=0, rx_done=0, parity_err=0, frame_err=0.
REQ-027 Reset mid-frame SHALL abort the frame with no rx_done; the next full frame SHALL be received normally.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: the PARITY state is present as in REQ-018, matching the transmitter frame format.
REQ-029 Macro undefined: DATA goes directly to STOP, and parity_err is tied to 0.

Structure
REQ-030 Package uart_pkg SHALL hold: the enum uart_state_e {IDLE, START, DATA, PARITY, STOP}, the constant OVERSAMPLE=16, and the parity-type constants EVEN=0 and ODD=1.
REQ-031 The synchronizer SHALL be the sub-module uart_rx_sync: one bit wide, reset value 1, synchronous active-high reset.

Verification (UART_RX_PARITY_EN defined, defaults, tick every 4 clk)
REQ-032 Frame 0xA5, parity 0, stop 1 -> one rx_done pulse; rx_data=0xA5; parity_err=0; frame_err=0.
REQ-033 Frame 0xA5 with parity bit 1 -> rx_done; rx_data=0xA5; parity_err=1; frame_err=0.
REQ-034 Frame 0x3C with stop bit 0 -> rx_done; rx_data=0x3C; frame_err=1.
REQ-035 rx low for 4 ticks, then high -> no rx_done; FSM back in IDLE; a following 0x5A frame is received correctly.
REQ-036 rst=1 for 1 clk during the 4th data bit -> no rx_done; outputs at reset values; a following 0x3C frame gives rx_data=0x3C with no errors.
REQ-037 Back-to-back frames 0x00 then 0xFF from the transmitter with PAR_TYP=1 -> two rx_done pulses; data 0x00 then 0xFF; no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, oversampling ratio
// and parity-type selectors.
package uart_pkg;

    // Baud ticks per serial bit.
    localparam int unsigned OVERSAMPLE = 16;

    // Parity-type selectors for PAR_TYP.
    localparam int unsigned EVEN = 0;
    localparam int unsigned ODD  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for one asynchronous bit.
// Both flops reset to 1, the idle level of a serial line.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability stage followed by the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling. Data is sent LSB first, and each bit
// is sampled mid-bit. The frame has one start bit, DATA_BITS data bits, an
// optional parity bit and a stop period of SB_TICK ticks.
// Build option: define UART_RX_PARITY_EN to expect a parity bit after the
// data. Without it, DATA goes straight to STOP and parity_err is tied to 0.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   tick       - one-clk baud strobe at 16x the bit rate
//   rx         - asynchronous serial input, idle high
//   rx_data    - last received word, registered
//   rx_done    - one-clk pulse per completed frame (good or errored)
//   parity_err - parity mismatch on the last frame, held until next rx_done
//   frame_err  - stop bit sampled low on the last frame, held likewise
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PAR_TYP   = EVEN,
    parameter int unsigned SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err
);

    // The tick counter is 4 bits and widens only for stop periods above 16 ticks.
    localparam int unsigned TICK_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // Parameter sanity checks, evaluated at elaboration.
    if (PAR_TYP > ODD) begin : g_bad_par_typ
        $error("uart_rx: PAR_TYP must be 0 (even) or 1 (odd)");
    end
    if (DATA_BITS == 0 || SB_TICK == 0) begin : g_bad_size
        $error("uart_rx: DATA_BITS and SB_TICK must be non-zero");
    end

    logic                 rx_s;

    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    s_q, s_d;
    logic [BIT_W-1:0]     n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;

    logic [DATA_BITS-1:0] data_d;
    logic                 done_d;
    logic                 ferr_d;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic perr_out_d;
    logic exp_par;

    // Parity bit the transmitter should have sent for the shifted-in word.
    assign exp_par = (PAR_TYP == ODD) ? ~(^b_q) : (^b_q);
`endif

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            n_q        <= n_d;
            b_q        <= b_d;
            rx_data    <= data_d;
            rx_done    <= done_d;
            frame_err  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
            parity_err <= perr_out_d;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Next-state and output logic. Apart from the start detect in IDLE,
    // everything advances only on tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = rx_data;
        done_d  = 1'b0;
        ferr_d  = frame_err;
`ifdef UART_RX_PARITY_EN
        perr_d     = perr_q;
        perr_out_d = parity_err;
`endif

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                    n_d     = '0;
                end
            end

            // Recheck the line in the middle of the start bit to reject glitches.
            START: begin
                if (tick) begin
                    if (s_q == TICK_MID) begin
                        s_d     = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end
            end

            // Shift right with the new bit entering at the MSB, so the LSB ends up at bit 0.
            DATA: begin
                if (tick) begin
                    if (s_q == TICK_LAST) begin
                        s_d = '0;
                        b_d = DATA_BITS'({rx_s, b_q} >> 1);
                        if (n_q == BIT_LAST) begin
                            n_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + BIT_W'(1);
                        end
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == TICK_LAST) begin
                        s_d     = '0;
                        perr_d  = (rx_s != exp_par);
                        state_d = STOP;
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end
            end
`endif

            // The stop sample completes the frame whether or not it is errored.
            STOP: begin
                if (tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = '0;
                        state_d = IDLE;
                        data_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_out_d = perr_q;
`endif
                    end else begin
                        s_d = s_q + TICK_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Each transmitted frame pushes its expected
// word and error flags into a queue. An independent monitor pops an entry
// and compares it on every rx_done. Parity bits in the vectors are
// hand-computed for odd parity (PAR_TYP=1).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_HALF = 5;
    localparam int unsigned BIT_CLKS = 64;   // 16 ticks x 4 clk
    localparam int unsigned TB_PAR   = 1;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_done = 1'b0;

    uart_rx #(
        .DATA_BITS (8),
        .PAR_TYP   (TB_PAR),
        .SB_TICK   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #CLK_HALF clk = ~clk;
    end

    // Baud strobe: one clk high out of every four.
    initial begin
        int tcnt;
        tcnt = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % 4;
            tick = (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every rx_done must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rx_done) begin
            check("single_pulse", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_rx_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("parity_err", 32'(parity_err), 32'(e.perr));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
            end
        end
        prev_done = rx_done;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT_CLKS);
    endtask

    // Transmit one frame. A low stop bit is released shortly after mid-bit so the
    // line does not look like a new start bit once the receiver returns to IDLE.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic exp_perr, input logic exp_ferr);
        exp_t e;
        e.data = d;
        e.perr = PAR_EN ? exp_perr : 1'b0;
        e.ferr = exp_ferr;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par);
        if (stop) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            idle(40);
            rx = 1'b1;
            idle(BIT_CLKS - 40);
        end
    endtask

    // Wait, with a bound, until every expected frame has been reported.
    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 4 * BIT_CLKS) begin
            idle(1);
            waited++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        idle(BIT_CLKS);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(1);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_done", 32'(rx_done), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        idle(20);

        // Good frame: 0xA5 has four ones, so the odd parity bit is 1.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("frame_a5_done");

        // Wrong parity bit.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        drain("frame_a5_perr_done");

        // Stop bit low.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("frame_3c_ferr_done");

        // False start: low for 4 ticks only.
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(2 * BIT_CLKS);
        check("false_start_idle", 32'(dut.state_q), 32'(IDLE));
        check("false_start_hold_data", 32'(rx_data), 32'h3C);
        check("false_start_hold_ferr", 32'(frame_err), 32'd1);

        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("frame_5a_done");

        // Reset during the 4th data bit of 0x3C (bit 3 = 1).
        rx = 1'b0;
        idle(BIT_CLKS);
        rx = 1'b0; idle(BIT_CLKS);
        rx = 1'b0; idle(BIT_CLKS);
        rx = 1'b1; idle(BIT_CLKS);
        rx = 1'b1; idle(20);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midreset_rx_data", 32'(rx_data), 32'h0);
        check("midreset_rx_done", 32'(rx_done), 32'h0);
        check("midreset_parity_err", 32'(parity_err), 32'h0);
        check("midreset_frame_err", 32'(frame_err), 32'h0);
        check("midreset_state", 32'(dut.state_q), 32'(IDLE));
        idle(12 * BIT_CLKS);

        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("frame_3c_after_reset_done");

        // Back-to-back frames with no idle gap. Odd parity is 1 for both 0x00 and 0xFF.
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        drain("back_to_back_done");

        idle(2 * BIT_CLKS);
        check("no_outstanding_frames", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
